// File: rtl/controlador_vga.sv
// rtl/controlador_vga.sv - VGA 640x480@60 raster timing, pixel coordinates and framebuffer read address.
// Optional VGA_DIV2_EN: pixel tick on every second clock for a 50 MHz board clock.
module controlador_vga #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int ADDR_W    = 19
) (
  input  logic              clock,
  input  logic              reset,
  output logic [9:0]        posicionX,
  output logic [9:0]        posicionY,
  output logic [ADDR_W-1:0] direccionMemoria,
  output logic              visible,
  output logic              hsync,
  output logic              vsync,
  output logic              pixelTick,
  output logic              finCuadro
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HVIS     = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] HMAX     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VVIS     = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] VMAX     = 10'(V_TOTAL - 1);

  logic [9:0]        hc;
  logic [9:0]        vc;
  logic [ADDR_W-1:0] addr_cnt;
  logic              tick;
  logic              vis_d;
  logic              hs_d;
  logic              vs_d;
  logic              last_d;
  logic              last_vis_d;

`ifdef VGA_DIV2_EN
  // Phase flop also acts as the reset-release synchroniser: first tick on the second edge.
  logic phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) phase <= 1'b0;
    else        phase <= ~phase;
  end

  assign tick = phase;
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    vis_d      = 1'b0;
    hs_d       = 1'b1;
    vs_d       = 1'b1;
    last_d     = 1'b0;
    last_vis_d = 1'b0;
    vis_d      = (hc < HVIS) && (vc < VVIS);
    hs_d       = !((hc >= HS_START) && (hc < HS_END));
    vs_d       = !((vc >= VS_START) && (vc < VS_END));
    last_d     = (hc == HMAX) && (vc == VMAX);
    last_vis_d = (hc == HVIS - 10'd1) && (vc == VVIS - 10'd1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hc               <= '0;
      vc               <= '0;
      addr_cnt         <= '0;
      posicionX        <= '0;
      posicionY        <= '0;
      direccionMemoria <= '0;
      visible          <= 1'b0;
      hsync            <= 1'b1;
      vsync            <= 1'b1;
      pixelTick        <= 1'b0;
      finCuadro        <= 1'b0;
    end else begin
      pixelTick <= tick;
      finCuadro <= tick && last_d;
      if (tick) begin
        posicionX <= hc;
        posicionY <= vc;
        visible   <= vis_d;
        hsync     <= hs_d;
        vsync     <= vs_d;
        // addr_cnt tracks the next visible pixel; blanking leaves the output holding.
        if (vis_d) begin
          direccionMemoria <= addr_cnt;
          addr_cnt         <= last_vis_d ? '0 : addr_cnt + ADDR_W'(1);
        end
        if (hc == HMAX) begin
          hc <= '0;
          vc <= (vc == VMAX) ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_controlador_vga.sv
// tb/tb_controlador_vga.sv - randomized-reset raster check of controlador_vga against a tick-index model.
module tb_controlador_vga;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clock;
  logic        reset;
  logic [9:0]  posicionX;
  logic [9:0]  posicionY;
  logic [18:0] direccionMemoria;
  logic        visible, hsync, vsync, pixelTick, finCuadro;

  controlador_vga #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ADDR_W(19)
  ) dut (
    .clock(clock), .reset(reset),
    .posicionX(posicionX), .posicionY(posicionY),
    .direccionMemoria(direccionMemoria), .visible(visible),
    .hsync(hsync), .vsync(vsync), .pixelTick(pixelTick), .finCuadro(finCuadro)
  );

  int checks = 0;
  int passed = 0;
  int k = 0;
  bit sb_on = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return {20'd0, posicionX, posicionY, direccionMemoria, visible, hsync, vsync, pixelTick, finCuadro};
  endfunction

  localparam logic [63:0] RESET_VEC = {20'd0, 10'd0, 10'd0, 19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Address of the most recent visible pixel at or before (h, v) in raster order.
  function automatic int exp_addr(int h, int v);
    if (v < VV) return (h < HV) ? v * HV + h : v * HV + HV - 1;
    return HV * VV - 1;
  endfunction

  // Edges seen since reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  int          sb_td, sb_idx, sb_h, sb_v;
  logic        sb_pt, sb_vis, sb_hs, sb_vs, sb_fin;
  logic [63:0] sb_exp;

  always @(negedge clock) begin
    if (sb_on) begin
`ifdef VGA_DIV2_EN
      sb_td = k / 2;
      sb_pt = (k > 0) && (k % 2 == 0);
`else
      sb_td = k;
      sb_pt = (k > 0);
`endif
      if (sb_td == 0) begin
        sb_exp = RESET_VEC;
      end else begin
        sb_idx = (sb_td - 1) % FRAME;
        sb_h   = sb_idx % HT;
        sb_v   = sb_idx / HT;
        sb_vis = (sb_h < HV) && (sb_v < VV);
        sb_hs  = !((sb_h >= HV + HF) && (sb_h < HV + HF + HS));
        sb_vs  = !((sb_v >= VV + VF) && (sb_v < VV + VF + VS));
        sb_fin = sb_pt && (sb_idx == FRAME - 1);
        sb_exp = {20'd0, 10'(sb_h), 10'(sb_v), 19'(exp_addr(sb_h, sb_v)),
                  sb_vis, sb_hs, sb_vs, sb_pt, sb_fin};
      end
      chk("raster", outs(), sb_exp);
    end
  end

  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clock);
      if (pixelTick) ok = 1;
    end
    if (!ok) chk("tick_timeout", 64'd0, 64'd1);
  endtask

  bit ok;
  int hs_low_l0, hs_bad, vs_low, fin_cnt, fin_t, wrap_t;

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    chk("reset_hold", outs(), RESET_VEC);
    sb_on = 1;
    reset = 1'b1;

    hs_low_l0 = 0; hs_bad = 0; vs_low = 0; fin_cnt = 0; fin_t = -1; wrap_t = -1;
    for (int t = 0; t <= FRAME; t++) begin
      wait_tick(ok);
      if (t == 0)
        chk("first_tick", {posicionX, posicionY, 1'b0, visible, direccionMemoria},
            {10'd0, 10'd0, 1'b0, 1'b1, 19'd0});
      if (t < FRAME) begin
        if (!vsync) vs_low++;
        if (finCuadro) begin fin_cnt++; fin_t = t; end
        if (posicionY == 0 && !hsync) begin
          hs_low_l0++;
          if (posicionX < 18 || posicionX > 21) hs_bad++;
        end
      end
      if (posicionY == 0 && posicionX == 15) chk("addr_15_0", 64'(direccionMemoria), 64'd15);
      if (posicionY == 0 && posicionX == 16) chk("vis_fall", 64'(visible), 64'd0);
      if (posicionY == 0 && posicionX == 20) chk("addr_hold", 64'(direccionMemoria), 64'd15);
      if (posicionY == 1 && posicionX == 0) begin
        chk("addr_0_1", 64'(direccionMemoria), 64'd16);
        wrap_t = t;
      end
      if (posicionY == 11 && posicionX == 15) chk("addr_last", 64'(direccionMemoria), 64'd191);
      if (t == FRAME)
        chk("frame_wrap", {25'd0, posicionX, posicionY, direccionMemoria}, 64'd0);
    end
    chk("hsync_ticks", 64'(hs_low_l0), 64'd4);
    chk("hsync_pos", 64'(hs_bad), 64'd0);
    chk("vsync_ticks", 64'(vs_low), 64'd50);
    chk("fin_count", 64'(fin_cnt), 64'd1);
    chk("fin_tick", 64'(fin_t), 64'd474);
    chk("line_wrap", 64'(wrap_t), 64'd25);

    ok = 0;
    for (int i = 0; i < 4 * FRAME && !ok; i++) begin
      @(negedge clock);
      if (pixelTick && posicionX == 20 && posicionY == 7) ok = 1;
    end
    if (!ok) chk("midframe_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1 chk("reset_midframe", outs(), RESET_VEC);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    wait_tick(ok);
    chk("restart", {posicionX, posicionY, 1'b0, visible, direccionMemoria},
        {10'd0, 10'd0, 1'b0, 1'b1, 19'd0});

    repeat (6) begin
      repeat ($urandom_range(20, 700)) @(negedge clock);
      @(posedge clock);
      #($urandom_range(1, 3)) reset = 1'b0;
      #1 chk("reset_async", outs(), RESET_VEC);
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #3 reset = 1'b1;
    end
    repeat (FRAME + 50) @(negedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/controlador_vga.md
# controlador_vga

Generates VGA 640x480@60 raster timing and drives the pixel coordinates and framebuffer read address consumed by the screen-region colour stage. It produces `posicionX`/`posicionY` for the colour stage, a linear read address into the 3-bit-per-pixel video memory, and active-low `hsync`/`vsync` to the DAC connector.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `ADDR_W`, 19, framebuffer address width; must hold `H_VISIBLE*V_VISIBLE-1`
- `clock`  in  1  system clock; the only clock
- `reset`  in  1  asynchronous, active-low reset
- `posicionX`  out  10  current horizontal count, 0..799
- `posicionY`  out  10  current vertical count, 0..524
- `direccionMemoria`  out  ADDR_W  linear framebuffer read address
- `visible`  out  1  high while the current pixel lies in the 640x480 area
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `pixelTick`  out  1  one-clock pulse on each clock in which the outputs update
- `finCuadro`  out  1  one-clock pulse on the update that presents (799,524)

## Operation
- Internal counters:
  - `hc` counts 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (800).
  - `vc` counts 0..V_TOTAL-1, with V_TOTAL = sum of the V_* parameters (525).
- All outputs are registered and update only on a pixel tick. On each tick:
  - Outputs present the decode of the current (`hc`, `vc`).
  - Then `hc` increments.
  - When `hc` reaches H_TOTAL-1 it wraps to 0 and `vc` increments.
  - When `vc` also reaches V_TOTAL-1 it wraps to 0.
- Decodes for counter value (h, v):
  - `visible` = h < H_VISIBLE && v < V_VISIBLE.
  - `hsync` = 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - `vsync` = 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
- `direccionMemoria` equals v*H_VISIBLE+h for visible pixels.
  - Maintained incrementally; no multiplier.
  - Holds its last value through blanking.
  - Returns to 0 on the tick presenting (0,0).
- `finCuadro` is high only on the update presenting h=H_TOTAL-1, v=V_TOTAL-1.
- `pixelTick` is asserted on exactly the clocks in which the output registers load.

## Timing
- Reset (async assert, outputs forced immediately):
  - `hc`=`vc`=0.
  - `posicionX`=`posicionY`=0, `direccionMemoria`=0.
  - `visible`=0, `hsync`=1, `vsync`=1, `pixelTick`=0, `finCuadro`=0.
- Reset release is synchronised internally. The first tick happens no earlier than the first clock edge after deassertion.
- Latency:
  - The first tick presents (0,0) with `visible`=1 and `direccionMemoria`=0.
  - Each later tick advances the presented pixel by exactly one.
- Data alignment: video memory returns data one clock after the address. The colour stage registers `posicionX`/`posicionY` by one clock to align with `readValueMemory`. This block adds no extra skew.
- Wrap-around:
  - Line end: the tick after h=799 presents h=0, v+1.
  - Frame end: the tick after (799,524) presents (0,0).
- Reset mid-frame: counters return to 0 asynchronously. No partial sync pulse is extended; `hsync`/`vsync` go high immediately.
- Frame period is H_TOTAL*V_TOTAL ticks, i.e. 420000.

## Configuration
- `VGA_DIV2_EN` defined:
  - A divide-by-2 enable toggles every clock, for a 50 MHz board clock.
  - A tick occurs on every second clock; the first tick is on the second clock edge after reset release.
  - `pixelTick` is high 1 of every 2 clocks. Outputs hold between ticks.
- `VGA_DIV2_EN` undefined:
  - Every clock is a tick (25 MHz pixel clock supplied).
  - `pixelTick` is constantly 1 after the first edge following reset release.

## Test plan
- **Reset values:** hold `reset`=0 for 3 clocks, then release.
  - During reset: all outputs equal their reset values, with `hsync`=`vsync`=1 and `visible`=0.
  - First tick presents (0,0), `visible`=1, `direccionMemoria`=0.
- **Horizontal timing:** run one line.
  - `hsync` is low for exactly 96 ticks, at presented h=656..751.
  - `visible` falls at h=640.
  - h=799 is followed by h=0 with `posicionY`=1.
- **Addressing:**
  - Presented (639,0) gives address 639.
  - Address holds at 639 through blanking.
  - (0,1) gives 640.
  - (639,479) gives 307199.
  - Next frame's (0,0) gives 0.
- **Vertical and frame end:** run a full frame.
  - `vsync` is low on lines 490..491 only, i.e. 1600 ticks.
  - `finCuadro` pulses once, at (799,524).
  - Frame length is 420000 ticks.
- **Reset mid-frame:** assert `reset` at presented (700,300).
  - Outputs reset immediately.
  - After release, the raster restarts at (0,0) with address 0.
- **Divide-by-2 (`VGA_DIV2_EN` defined):**
  - `pixelTick` alternates 1/0.
  - `posicionX` advances once per 2 clocks.
  - `hsync` low spans 192 clocks.
